ibex_ifetch_arbiter: RTL and testbench
======================================

# ibex_ifetch_arbiter

Shares the single instruction-memory port between two fetch requesters: requester 0, the prefetch buffer, and requester 1, a secondary fetch source such as the debug-ROM or instruction-cache fill path. It arbitrates round-robin, locking the choice for each request until it is granted. It records the owner of every granted transaction in order, so each in-order response is routed back to the requester that issued it. It sits between the prefetch buffer's instr_* bus and the core's instruction bus.

## Interface
- MaxOutstanding, 4: maximum granted-but-unanswered transactions on the memory port (power of two, ≥2).
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  2  per-requester request.
- addr_i  in  64  per-requester byte address; requester i occupies bits [32i+31:32i].
- gnt_o  out  2  per-requester grant.
- rvalid_o  out  2  per-requester response valid.
- rdata_o  out  32  response data, shared by both requesters.
- err_o  out  1  response error, shared by both requesters.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  memory address, word-aligned (bits [1:0] = 0).
- instr_gnt_i  in  1  memory grant.
- instr_rvalid_i  in  1  memory response valid.
- instr_rdata_i  in  32  memory response data.
- instr_err_i  in  1  memory response error.
- busy_o  out  1  high when a request is active or outstanding.

## Operation
- **Requester contract:** once req_i[i] rises, req_i[i] and addr_i[i] stay stable until gnt_o[i].
- **Arbiter state machine**
  - States: IDLE and LOCKED.
  - In IDLE with count < MaxOutstanding, select a requester:
    - If only one requests, it wins.
    - If both request, the requester not granted most recently wins (rr_last_q, reset 1, so requester 0 wins first).
  - If the selected request is not granted in the same cycle, store it in owner_sel_q and go to LOCKED.
  - In LOCKED, drive only owner_sel_q, independent of the other requester and of count. Return to IDLE on instr_gnt_i.
  - A grant taken directly from IDLE stays in IDLE.
- **Memory-side outputs**
  - instr_req_o = selected requester's req_i.
  - instr_addr_o = {addr[31:2], 2'b00} of the selected requester.
  - When count == MaxOutstanding in IDLE, instr_req_o = 0 and no gnt_o is issued.
- **Grant routing:** gnt_o[i] = instr_gnt_i & instr_req_o & (selected == i). On each grant, rr_last_q ← i.
- **Owner FIFO**
  - Depth MaxOutstanding, 1-bit entries, in-order.
  - Push the owner on instr_req_o & instr_gnt_i.
  - Pop on instr_rvalid_i.
  - count is $clog2(MaxOutstanding)+1 bits wide.
  - Simultaneous push and pop leaves count unchanged. Read and write pointers wrap modulo MaxOutstanding.
- **Response routing**
  - rvalid_o[i] = instr_rvalid_i & (head owner == i) & (count != 0).
  - rdata_o = instr_rdata_i and err_o = instr_err_i, passed through unconditionally.
- **Error cases**
  - instr_rvalid_i with count == 0 is a protocol error: the response is dropped, count stays 0, and a simulation assertion fires.
  - A requester dropping req_i while LOCKED triggers a simulation assertion; RTL behaviour stays locked on that requester.
- busy_o = instr_req_o | (count != 0).

## Timing
- Reset values:
  - state = IDLE, count = 0, rr_last_q = 1, pointers = 0.
  - All outputs 0 except the combinational passthroughs of instr_rdata_i and instr_err_i.
- Zero-cycle combinational paths: req/addr → instr_req/instr_addr, instr_gnt_i → gnt_o, instr_rvalid_i → rvalid_o.
- No combinational path from instr_rvalid_i to instr_req_o. A pop frees a slot only from the next cycle.
- Response may arrive the cycle after grant at the earliest. The owner is visible at the FIFO head in that cycle.
- Reset mid-operation clears all state. The memory port must be quiescent at reset release.

## Structure
- Add to ibex_pkg: typedef `ifetch_owner_e` {IFETCH_OWNER_PF = 1'b0, IFETCH_OWNER_AUX = 1'b1} and typedef `ifetch_arb_state_e` {ARB_IDLE, ARB_LOCKED}.
- One sub-module, ibex_ifetch_owner_fifo, parameterised by Depth. Ports: push, push_owner, pop, head_owner, count, full, empty.
- The arbiter FSM and routing stay in the top module.

## Test plan
- **Single requester:** req_i=2'b01, addr 0x0000_1006, gnt next cycle.
  - Expect instr_addr_o = 0x0000_1004 and gnt_o = 2'b01.
  - Expect rvalid_o = 2'b01 with rdata 0xDEAD_BEEF.
- **Contention round-robin:** both requesting, immediate grants every cycle. Expect grant order 0,1,0,1 and responses routed 0,1,0,1.
- **Lock:** req0 held, gnt withheld 3 cycles, req1 asserted meanwhile.
  - Expect instr_addr_o stays on requester 0's address throughout.
  - Expect requester 1 granted on the next arbitration.
- **Full:** 4 grants with no rvalid.
  - Expect instr_req_o = 0 while count = 4.
  - Expect instr_req_o may rise one cycle after the first rvalid.
- **Simultaneous push/pop at count = 2:** expect count to stay 2 and the pointer to wrap from 3 to 0 correctly.
- **Reset mid-operation:** rst_ni low with count = 3 and state LOCKED. Expect all outputs 0 and count 0 after release.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the instruction-fetch arbiter slice.
//   ifetch_owner_e     : which requester owns a memory transaction
//                        (PF = prefetch buffer, AUX = secondary fetch source).
//   ifetch_arb_state_e : arbiter state, IDLE (free to choose) or LOCKED
//                        (held on one requester until its grant arrives).
package ibex_pkg;

    typedef enum logic {
        IFETCH_OWNER_PF  = 1'b0,
        IFETCH_OWNER_AUX = 1'b1
    } ifetch_owner_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } ifetch_arb_state_e;

endpackage

// File: rtl/ibex_ifetch_owner_fifo.sv
// In-order record of transaction owners for the shared instruction port.
// One 1-bit entry is pushed per granted request and popped per response,
// so the head always names the requester the next response belongs to.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push          : store push_owner at the tail (ignored when full)
//   push_owner    : owner of the transaction being granted
//   pop           : drop the head entry (ignored when empty)
//   head_owner    : owner at the head (valid only when !empty)
//   count         : number of stored entries, 0..Depth
//   full, empty   : occupancy flags
module ibex_ifetch_owner_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  ifetch_owner_e              push_owner,
    input  logic                       pop,
    output ifetch_owner_e              head_owner,
    output logic [$clog2(Depth):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    ifetch_owner_e   mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            // Depth is a power of two, so pointer overflow is the wrap.
            if (push_ok) wptr_q <= wptr_q + PtrW'(1);
            if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it
    // has been written, because the head is qualified by !empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= push_owner;
    end

    assign head_owner = mem_q[rptr_q];
    assign count      = count_q;

endmodule

// File: rtl/ibex_ifetch_arbiter.sv
// Shares the single instruction-memory port between the prefetch buffer
// (requester 0) and a secondary fetch source (requester 1). Round-robin
// selection, locked on a requester from request until grant; the owner of
// every granted transaction is queued so in-order responses are routed back.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   req_i[1:0]       : per-requester request
//   addr_i[63:0]     : requester i address in bits [32i+31:32i]
//   gnt_o[1:0]       : per-requester grant
//   rvalid_o[1:0]    : per-requester response valid
//   rdata_o, err_o   : shared response data / error (passthrough)
//   instr_*          : memory-side request/grant/response
//   busy_o           : a request is active or a response is outstanding
module ibex_ifetch_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [63:0] addr_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    ifetch_arb_state_e state_q, state_d;
    ifetch_owner_e     owner_sel_q, owner_sel_d;
    ifetch_owner_e     rr_last_q;
    ifetch_owner_e     sel;
    ifetch_owner_e     head_owner;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_full, fifo_empty;
    logic              granted;

    // Only word addresses reach memory; the byte-offset bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[33:32], addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            owner_sel_q <= IFETCH_OWNER_PF;
            rr_last_q   <= IFETCH_OWNER_AUX;
        end else begin
            state_q     <= state_d;
            owner_sel_q <= owner_sel_d;
            if (granted) rr_last_q <= sel;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_sel_d = owner_sel_q;
        sel         = IFETCH_OWNER_PF;
        instr_req_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (req_i[0] && req_i[1]) begin
                    sel = (rr_last_q == IFETCH_OWNER_AUX) ? IFETCH_OWNER_PF
                                                          : IFETCH_OWNER_AUX;
                end else if (req_i[1]) begin
                    sel = IFETCH_OWNER_AUX;
                end
                // A full owner queue blocks new requests; the fill level is
                // registered, so a pop frees a slot only from the next cycle.
                instr_req_o = req_i[sel] & ~fifo_full;
                if (instr_req_o && !instr_gnt_i) begin
                    state_d     = ARB_LOCKED;
                    owner_sel_d = sel;
                end
            end
            ARB_LOCKED: begin
                sel         = owner_sel_q;
                instr_req_o = req_i[sel];
                if (instr_gnt_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign instr_addr_o = (sel == IFETCH_OWNER_AUX) ? {addr_i[63:34], 2'b00}
                                                    : {addr_i[31:2], 2'b00};
    assign granted  = instr_req_o & instr_gnt_i;
    assign gnt_o    = {granted & (sel == IFETCH_OWNER_AUX),
                       granted & (sel == IFETCH_OWNER_PF)};

    ibex_ifetch_owner_fifo #(
        .Depth (MaxOutstanding)
    ) u_owner_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (granted),
        .push_owner (sel),
        .pop        (instr_rvalid_i),
        .head_owner (head_owner),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign rvalid_o = {instr_rvalid_i & ~fifo_empty & (head_owner == IFETCH_OWNER_AUX),
                       instr_rvalid_i & ~fifo_empty & (head_owner == IFETCH_OWNER_PF)};
    assign rdata_o  = instr_rdata_i;
    assign err_o    = instr_err_i;
    assign busy_o   = instr_req_o | (fifo_count != '0);

    // Protocol checks: a response with nothing outstanding is dropped, and a
    // locked requester must hold its request until granted.
    rvalid_without_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(instr_rvalid_i && fifo_empty))
        else $error("ibex_ifetch_arbiter: instr_rvalid_i with no outstanding request");

    locked_request_dropped: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(state_q == ARB_LOCKED && !req_i[owner_sel_q]))
        else $error("ibex_ifetch_arbiter: locked requester dropped req_i");

endmodule

// File: tb/tb_ibex_ifetch_arbiter.sv
// Directed bench for ibex_ifetch_arbiter. Inputs change 1 time unit after a
// rising edge; combinational outputs are sampled 1 unit later.
module tb_ibex_ifetch_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_i;
    logic [63:0] addr_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ibex_ifetch_arbiter #(.MaxOutstanding(4)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .addr_i         (addr_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_ni         = 1'b0;
        req_i          = '0;
        addr_i         = '0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        req_i = '0; addr_i = '0; instr_gnt_i = 0; instr_rvalid_i = 0;
        instr_rdata_i = 32'h1234_5678; instr_err_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", instr_addr_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL reset_rdata_pass: got %h want 12345678", rdata_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL reset_err_pass: got %b want 1", err_o); end
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        req_i = 2'b01; addr_i = {32'h0, 32'h0000_1006};
        #1;
        checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h0000_1004) begin errors++; $display("FAIL single_addr: got %h want 00001004", instr_addr_o); end
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL single_nognt: got %b want 00", gnt_o); end
        tick();
        instr_gnt_i = 1'b1;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", gnt_o); end
        checks++; if (instr_addr_o !== 32'h0000_1004) begin errors++; $display("FAIL single_addr_gnt: got %h want 00001004", instr_addr_o); end
        tick();
        req_i = 2'b00; instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (rvalid_o !== 2'b01) begin errors++; $display("FAIL single_rvalid: got %b want 01", rvalid_o); end
        checks++; if (rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rdata_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_o); end
        tick();
        instr_rvalid_i = 0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        do_reset();
        req_i = 2'b11; addr_i = {32'h0000_0200, 32'h0000_0100}; instr_gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 32'h100 : 32'h200;
            #1;
            checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_o, exp_g); end
            checks++; if (instr_addr_o !== exp_a) begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", i, instr_addr_o, exp_a); end
            tick();
        end
        req_i = 2'b00; instr_gnt_i = 0; instr_rvalid_i = 1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (rvalid_o !== exp_g) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rvalid_o, exp_g); end
            tick();
        end
        instr_rvalid_i = 0;
    endtask

    task automatic test_lock;
        logic [1:0] exp_r [3];
        exp_r = '{2'b01, 2'b10, 2'b01};
        do_reset();
        req_i = 2'b01; addr_i = {32'h0000_0400, 32'h0000_0300}; instr_gnt_i = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_i = 2'b11;
            #1;
            checks++; if (instr_addr_o !== 32'h300) begin errors++; $display("FAIL lock_addr[%0d]: got %h want 00000300", c, instr_addr_o); end
            checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL lock_req[%0d]: got %b want 1", c, instr_req_o); end
            checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL lock_nognt[%0d]: got %b want 00", c, gnt_o); end
            tick();
        end
        instr_gnt_i = 1;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_gnt0: got %b want 01", gnt_o); end
        checks++; if (instr_addr_o !== 32'h300) begin errors++; $display("FAIL lock_addr_gnt: got %h want 00000300", instr_addr_o); end
        tick();
        addr_i = {32'h0000_0400, 32'h0000_0500};
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL lock_next_gnt1: got %b want 10", gnt_o); end
        checks++; if (instr_addr_o !== 32'h400) begin errors++; $display("FAIL lock_next_addr: got %h want 00000400", instr_addr_o); end
        tick();
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_after_gnt0: got %b want 01", gnt_o); end
        tick();
        req_i = 2'b00; instr_gnt_i = 0; instr_rvalid_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rvalid_o !== exp_r[i]) begin errors++; $display("FAIL lock_rvalid[%0d]: got %b want %b", i, rvalid_o, exp_r[i]); end
            tick();
        end
        instr_rvalid_i = 0;
    endtask

    task automatic test_full;
        do_reset();
        req_i = 2'b01; addr_i = {32'h0, 32'h0000_0600}; instr_gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL full_fill_gnt[%0d]: got %b want 01", i, gnt_o); end
            tick();
        end
        instr_gnt_i = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL full_req_blocked[%0d]: got %b want 0", i, instr_req_o); end
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy[%0d]: got %b want 1", i, busy_o); end
            tick();
        end
        instr_rvalid_i = 1;
        #1;
        checks++; if (rvalid_o !== 2'b01) begin errors++; $display("FAIL full_first_rvalid: got %b want 01", rvalid_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL full_req_same_cycle: got %b want 0", instr_req_o); end
        tick();
        instr_rvalid_i = 0; instr_gnt_i = 1;
        #1;
        checks++; if (instr_req_o !== 1'b1) begin errors++; $display("FAIL full_req_reopen: got %b want 1", instr_req_o); end
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL full_gnt_reopen: got %b want 01", gnt_o); end
        tick();
        req_i = 2'b00; instr_gnt_i = 0; instr_rvalid_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rvalid_o !== 2'b01) begin errors++; $display("FAIL full_drain[%0d]: got %b want 01", i, rvalid_o); end
            tick();
        end
        instr_rvalid_i = 0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_push_pop;
        logic [1:0] exp_d [4];
        logic [1:0] exp_p;
        exp_d = '{2'b01, 2'b10, 2'b01, 2'b01};
        do_reset();
        addr_i = {32'h0000_0A00, 32'h0000_0900};
        req_i = 2'b01; instr_gnt_i = 1;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL pp_prefill0: got %b want 01", gnt_o); end
        tick();
        req_i = 2'b10;
        #1;
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL pp_prefill1: got %b want 10", gnt_o); end
        tick();
        // Four cycles of grant+response at count 2; pointers pass 3 -> 0.
        instr_rvalid_i = 1;
        for (int i = 0; i < 4; i++) begin
            exp_p = (i % 2 == 0) ? 2'b01 : 2'b10;
            req_i = exp_p;
            #1;
            checks++; if (gnt_o !== exp_p) begin errors++; $display("FAIL pp_gnt[%0d]: got %b want %b", i, gnt_o, exp_p); end
            checks++; if (rvalid_o !== exp_p) begin errors++; $display("FAIL pp_rvalid[%0d]: got %b want %b", i, rvalid_o, exp_p); end
            tick();
        end
        // Still two outstanding: exactly two more grants fit.
        instr_rvalid_i = 0; req_i = 2'b01;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL pp_topup[%0d]: got %b want 01", i, gnt_o); end
            tick();
        end
        #1;
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL pp_full: got %b want 0", instr_req_o); end
        tick();
        req_i = 2'b00; instr_gnt_i = 0; instr_rvalid_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rvalid_o !== exp_d[i]) begin errors++; $display("FAIL pp_drain[%0d]: got %b want %b", i, rvalid_o, exp_d[i]); end
            tick();
        end
        instr_rvalid_i = 0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_i = 2'b01; addr_i = {32'h0000_0C00, 32'h0000_0B00}; instr_gnt_i = 1;
        repeat (3) tick();
        req_i = 2'b10; instr_gnt_i = 0;
        #1;
        checks++; if (instr_addr_o !== 32'hC00) begin errors++; $display("FAIL mid_lock_addr: got %h want 00000c00", instr_addr_o); end
        tick();
        rst_ni = 1'b0; req_i = 2'b00;
        #1;
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL mid_gnt: got %b want 00", gnt_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", instr_req_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_o); end
        tick(); tick();
        rst_ni = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy_release: got %b want 0", busy_o); end
        req_i = 2'b11; addr_i = {32'h0000_0800, 32'h0000_0700}; instr_gnt_i = 1;
        #1;
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL mid_rr_restart: got %b want 01", gnt_o); end
        checks++; if (instr_addr_o !== 32'h700) begin errors++; $display("FAIL mid_addr: got %h want 00000700", instr_addr_o); end
        tick();
        req_i = 2'b00; instr_gnt_i = 0; instr_rvalid_i = 1;
        #1;
        checks++; if (rvalid_o !== 2'b01) begin errors++; $display("FAIL mid_rvalid: got %b want 01", rvalid_o); end
        tick();
        instr_rvalid_i = 0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_final_idle: got %b want 0", busy_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
